// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode constants and FSM state encoding for the ALU family
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_LSL   = 4'b0011;
    localparam logic [3:0] OP_LSR   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add multiplier, one multiplier bit per cycle
module alu_mul_seq #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         done_o,
    output logic [N-1:0] product_o
);

    localparam int CW = $clog2(N);

    logic [N-1:0]  mcand_q;
    logic [N-1:0]  mplier_q;
    logic [N-1:0]  acc_q;
    logic [N-1:0]  acc_d;
    logic [CW-1:0] cnt_q;
    logic          run_q;

    // Partial sum including the current iteration; on the last iteration this
    // is the final product, so the top can capture it on the same edge.
    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = run_q && (cnt_q == CW'(N - 1));
    assign product_o = acc_d;

    // Load on start, then shift the multiplicand left and the multiplier right each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i) begin
            run_q    <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - handshaked ALU: single-cycle ops inline, MUL via iterative multiplier
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int N  = 64,
    parameter int SW = $clog2(N)
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         InValid,
    output logic         InReady,
    input  logic [N-1:0] BusA,
    input  logic [N-1:0] BusB,
    input  logic [3:0]   ALUCtrl,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [N-1:0] BusW,
    output logic         Zero,
    output logic         Negative,
    output logic         Carry,
    output logic         Overflow
);

    alu_state_e   state_q;
    logic [N-1:0] busw_q;
    logic         zero_q;
    logic         neg_q;
    logic         carry_q;
    logic         ovf_q;
    logic         valid_q;

    logic         accept;
    logic         mul_start;
    logic         mul_done;
    logic [N-1:0] mul_product;

    logic [N-1:0] res_w;
    logic         res_c;
    logic         res_v;
    logic [N:0]   sum_ext;
    logic [N-1:0] diff;
    logic         shift_big;

    // A finished result may be replaced in the same cycle it is consumed.
    assign InReady   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && OutReady);
    assign accept    = InValid && InReady;
    assign mul_start = accept && !Reset && (ALUCtrl == OP_MUL);

    alu_mul_seq #(.N(N)) u_mul (
        .clk       (CLK),
        .rst       (Reset),
        .start_i   (mul_start),
        .a_i       (BusA),
        .b_i       (BusB),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Single-cycle datapath; only sampled into registers on an accept.
    always_comb begin
        res_w     = '0;
        res_c     = 1'b0;
        res_v     = 1'b0;
        sum_ext   = {1'b0, BusA} + {1'b0, BusB};
        diff      = BusA - BusB;
        shift_big = |BusB[N-1:SW];
        case (ALUCtrl)
            OP_AND:   res_w = BusA & BusB;
            OP_OR:    res_w = BusA | BusB;
            OP_ADD: begin
                res_w = sum_ext[N-1:0];
                res_c = sum_ext[N];
                res_v = (BusA[N-1] == BusB[N-1]) && (sum_ext[N-1] != BusA[N-1]);
            end
            OP_SUB: begin
                res_w = diff;
                res_c = (BusA >= BusB);
                res_v = (BusA[N-1] != BusB[N-1]) && (diff[N-1] != BusA[N-1]);
            end
            OP_LSL:   res_w = shift_big ? '0 : (BusA << BusB[SW-1:0]);
            OP_LSR:   res_w = shift_big ? '0 : (BusA >> BusB[SW-1:0]);
            OP_PASSB: res_w = BusB;
            default:  res_w = '0;
        endcase
    end

    // Control FSM with registered result and flags; reset beats any accept.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busw_q  <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            if (ALUCtrl == OP_MUL) begin
                state_q <= ST_BUSY;
                valid_q <= 1'b0;
            end else begin
                state_q <= ST_DONE;
                valid_q <= 1'b1;
                busw_q  <= res_w;
                zero_q  <= (res_w == '0);
                neg_q   <= res_w[N-1];
                carry_q <= res_c;
                ovf_q   <= res_v;
            end
        end else begin
            case (state_q)
                ST_BUSY: begin
                    if (mul_done) begin
                        state_q <= ST_DONE;
                        valid_q <= 1'b1;
                        busw_q  <= mul_product;
                        zero_q  <= (mul_product == '0);
                        neg_q   <= mul_product[N-1];
                        carry_q <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (OutReady) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign OutValid = valid_q;
    assign BusW     = busw_q;
    assign Zero     = zero_q;
    assign Negative = neg_q;
    assign Carry    = carry_q;
    assign Overflow = ovf_q;

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter N, default 64, giving the operand and result width in bits; legal values are powers of two, 8 to 64.
REQ-002 The block SHALL have parameter SW, default $clog2(N), giving the width of the shift-amount field.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port InValid, input, 1 bit: operands and opcode are valid this cycle.
REQ-006 The block SHALL have port InReady, output, 1 bit: the block accepts an operation this cycle.
REQ-007 The block SHALL have port BusA, input, N bits: first operand.
REQ-008 The block SHALL have port BusB, input, N bits: second operand, or shift amount.
REQ-009 The block SHALL have port ALUCtrl, input, 4 bits: opcode.
REQ-010 The block SHALL have port OutValid, output, 1 bit: the result and flags are valid.
REQ-011 The block SHALL have port OutReady, input, 1 bit: downstream consumes the result this cycle.
REQ-012 The block SHALL have port BusW, output, N bits: registered result.
REQ-013 The block SHALL have port Zero, output, 1 bit: registered flag, BusW == 0.
REQ-014 The block SHALL have port Negative, output, 1 bit: registered flag, BusW[N-1].
REQ-015 The block SHALL have port Carry, output, 1 bit: registered carry flag.
REQ-016 The block SHALL have port Overflow, output, 1 bit: registered signed-overflow flag.

Function
REQ-017 Opcodes SHALL be: AND=0000, OR=0001, ADD=0010, LSL=0011, LSR=0100, SUB=0110, PassB=0111, MUL=1000; any other code yields BusW=0.
REQ-018 An operation SHALL be accepted, and its operands and opcode captured, on a rising edge where InValid && InReady.
REQ-019 The FSM SHALL have three states: IDLE, BUSY and DONE.
- IDLE -> DONE on a non-MUL accept.
- IDLE -> BUSY on a MUL accept.
- BUSY -> DONE after N iterations.
- DONE -> IDLE on OutReady with no new accept.
- DONE -> DONE or BUSY on OutReady with a new accept.
REQ-020 InReady SHALL equal (state==IDLE) || (state==DONE && OutReady), so back-to-back operations are allowed; InReady SHALL be 0 in BUSY.
REQ-021 Non-MUL ops SHALL have a latency of 1: OutValid=1 on the cycle after the accept.
REQ-022 MUL ops SHALL have a latency of N+1: an iterative shift-add takes one bit per cycle, and the result is the low N bits of the unsigned product.
REQ-023 OutValid SHALL be 1 exactly in DONE; BusW and all flags SHALL hold stable while OutValid && !OutReady.
REQ-024 ADD/SUB SHALL be modulo 2^N.
- Carry = carry-out for ADD; Carry = NOT borrow for SUB (A>=B unsigned gives 1).
- Overflow = two's-complement signed overflow.
REQ-025 For all other ops, Carry and Overflow SHALL be 0.
REQ-026 LSL/LSR SHALL be logical shifts by BusB[SW-1:0]; if BusB >= N, the result SHALL be 0.
REQ-027 Zero and Negative SHALL be computed from the registered result for every op, including undefined codes.
REQ-028 Inputs presented while InReady=0 SHALL be ignored and SHALL NOT disturb a MUL in progress.

Reset
REQ-029 On Reset=1 at a rising edge, the state SHALL go to IDLE and BusW, Zero, Negative, Carry, Overflow and OutValid SHALL go to 0.
REQ-030 Reset SHALL override acceptance in the same cycle.
REQ-031 Reset mid-MUL SHALL abandon the MUL; no result is ever emitted for it.
REQ-032 InReady SHALL be 1 in the first cycle after Reset deasserts.

Structure
REQ-033 The opcode constants and the FSM state encoding SHALL live in shared package alu_pkg, which any later ALU variant also uses.
REQ-034 The iterative multiplier SHALL be sub-module alu_mul_seq, parametrised by N, with start, done and product ports; all other ops SHALL be computed inline.
REQ-035 There SHALL be no combinational path from any input to BusW or to any flag.

Verification
REQ-036 With N=64, ADD A=FFFF_FFFF_FFFF_FFFF, B=1 -> one cycle later: BusW=0, Zero=1, Carry=1, Overflow=0.
REQ-037 With N=64, SUB A=8000_0000_0000_0000, B=1 -> BusW=7FFF_FFFF_FFFF_FFFF, Overflow=1, Carry=1, Negative=0.
REQ-038 With N=64, MUL A=3, B=5 -> InReady=0 for 64 cycles, then OutValid=1 with BusW=15; a second InValid during BUSY is ignored.
REQ-039 LSL A=1, B=64 -> BusW=0, Zero=1; LSR A=8000_0000_0000_0000, B=63 -> BusW=1.
REQ-040 Backpressure: hold OutReady=0 for 5 cycles after an OR -> BusW and flags are stable for all 5 cycles; with a new op presented on the OutReady=1 cycle -> it is accepted that cycle, with no bubble.
REQ-041 Reset asserted at cycle 10 of a MUL -> next cycle: IDLE, OutValid=0, BusW=0, InReady=1; no stale result appears afterwards.
